// File: rtl/div_rate_serializer_pkg.sv
// Shared definitions for the divider-rate serial frame transmitter:
// FSM state encodings, tap select codes and the idle line level.
package div_rate_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } ser_state_e;

  localparam logic [1:0] RATE_DIV2  = 2'd0;
  localparam logic [1:0] RATE_DIV4  = 2'd1;
  localparam logic [1:0] RATE_DIV8  = 2'd2;
  localparam logic [1:0] RATE_DIV16 = 2'd3;

  localparam logic SER_IDLE_LVL = 1'b1;

endpackage

// File: rtl/div_rate_serializer_tick_sel.sv
// Picks one divider tap and emits a one-cycle tick on its rising edge.
// The history register tracks every tap so a select change never fakes an edge.
module div_rate_serializer_tick_sel
  import div_rate_serializer_pkg::*;
(
  input  logic       reset,
  input  logic       iClkIN,
  input  logic       iDiv2,
  input  logic       iDiv4,
  input  logic       iDiv8,
  input  logic       iDiv16,
  input  logic [1:0] sel,
  output logic       tick
);

  logic [3:0] taps;
  logic [3:0] tap_hist_q;
  logic [3:0] tap_hist_d;
  logic       tap_now;
  logic       tap_prev;

  assign taps = {iDiv16, iDiv8, iDiv4, iDiv2};

  always_comb begin
    tap_hist_d = taps;
    tap_now    = taps[0];
    tap_prev   = tap_hist_q[0];
    case (sel)
      RATE_DIV2:  begin tap_now = taps[0]; tap_prev = tap_hist_q[0]; end
      RATE_DIV4:  begin tap_now = taps[1]; tap_prev = tap_hist_q[1]; end
      RATE_DIV8:  begin tap_now = taps[2]; tap_prev = tap_hist_q[2]; end
      RATE_DIV16: begin tap_now = taps[3]; tap_prev = tap_hist_q[3]; end
      default:    begin tap_now = taps[0]; tap_prev = tap_hist_q[0]; end
    endcase
    tick = tap_now & ~tap_prev;
  end

  always_ff @(posedge iClkIN or negedge reset) begin
    if (!reset) tap_hist_q <= '0;
    else        tap_hist_q <= tap_hist_d;
  end

endmodule

// File: rtl/div_rate_serializer.sv
// Parallel-to-serial frame transmitter paced by a selectable clock-divider tap:
// start bit, data LSB-first, optional even parity, then stop bit(s).
module div_rate_serializer
  import div_rate_serializer_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1,
  parameter int STOP_BITS = 1
) (
  input  logic              reset,
  input  logic              iClkIN,
  input  logic              iDiv2,
  input  logic              iDiv4,
  input  logic              iDiv8,
  input  logic              iDiv16,
  input  logic [1:0]        iRateSel,
  input  logic [DATA_W-1:0] iData,
  input  logic              iValid,
  output logic              oReady,
  output logic              oSer,
  output logic              oBusy,
  output logic              oFrameDone
);

  localparam int                CNT_W     = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

  ser_state_e        state_q, state_d;
  logic [1:0]        rate_q, rate_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              par_q, par_d;
  logic              ser_q, ser_d;
  logic              done_q, done_d;
  logic              tick;
  logic              accept;

  // Rate select is the latched copy, so iRateSel moves mid-frame are ignored.
  div_rate_serializer_tick_sel u_tick_sel (
    .reset  (reset),
    .iClkIN (iClkIN),
    .iDiv2  (iDiv2),
    .iDiv4  (iDiv4),
    .iDiv8  (iDiv8),
    .iDiv16 (iDiv16),
    .sel    (rate_q),
    .tick   (tick)
  );

  assign accept = iValid & oReady;

  always_ff @(posedge iClkIN or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_ARM;
      ST_ARM:    if (tick)   state_d = ST_START;
      ST_START:  if (tick)   state_d = ST_DATA;
      ST_DATA:   if (tick && (bit_cnt_q == LAST_BIT))
                   state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick)   state_d = ST_STOP;
      ST_STOP:   if (tick && (stop_cnt_q == LAST_STOP)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    oReady     = (state_q == ST_IDLE);
    oBusy      = (state_q != ST_IDLE);
    oSer       = ser_q;
    oFrameDone = done_q;
  end

  // Each tick launches the next line level; the parity accumulates the bits sent.
  always_comb begin
    rate_d     = rate_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    ser_d      = ser_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rate_d     = iRateSel;
          shift_d    = iData;
          par_d      = 1'b0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
        end
      end
      ST_ARM: begin
        if (tick) ser_d = 1'b0;
      end
      ST_START: begin
        if (tick) begin
          ser_d     = shift_q[0];
          par_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            ser_d      = (PARITY_EN != 0) ? par_q : SER_IDLE_LVL;
            stop_cnt_d = 1'b0;
          end else begin
            ser_d     = shift_q[0];
            par_d     = par_q ^ shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          ser_d      = SER_IDLE_LVL;
          stop_cnt_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_cnt_q == LAST_STOP) done_d = 1'b1;
          else                         stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: ser_d = SER_IDLE_LVL;
    endcase
  end

  always_ff @(posedge iClkIN or negedge reset) begin
    if (!reset) begin
      rate_q     <= RATE_DIV2;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      ser_q      <= SER_IDLE_LVL;
      done_q     <= 1'b0;
    end else begin
      rate_q     <= rate_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      ser_q      <= ser_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_div_rate_serializer.sv
// Bench for div_rate_serializer: vector table plus scoreboard-checked serial frames,
// with hand sequences for reset abort, mid-frame rate change and a stalled divider.
module tb_div_rate_serializer;

  localparam int DW = 8;

  logic          iClkIN = 1'b0;
  logic          reset  = 1'b0;
  logic [1:0]    iRateSel;
  logic [DW-1:0] iData;
  logic          iValid;
  logic          oReady, oSer, oBusy, oFrameDone;
  logic [3:0]    dcnt = '0;
  logic          div_hold;

  always #5 iClkIN = ~iClkIN;

  // Upstream binary divider model: registered taps, holdable at zero.
  always @(posedge iClkIN) begin
    if (div_hold) dcnt <= '0;
    else          dcnt <= dcnt + 1'b1;
  end

  div_rate_serializer #(.DATA_W(DW), .PARITY_EN(1), .STOP_BITS(1)) dut (
    .reset      (reset),
    .iClkIN     (iClkIN),
    .iDiv2      (dcnt[0]),
    .iDiv4      (dcnt[1]),
    .iDiv8      (dcnt[2]),
    .iDiv16     (dcnt[3]),
    .iRateSel   (iRateSel),
    .iData      (iData),
    .iValid     (iValid),
    .oReady     (oReady),
    .oSer       (oSer),
    .oBusy      (oBusy),
    .oFrameDone (oFrameDone)
  );

  typedef struct { logic [7:0] data; logic [1:0] rate; logic par; int p; } vec_t;
  typedef struct { logic [7:0] data; logic par; int p; int acc; } exp_t;

  exp_t sb[$];
  vec_t vt[8];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   mon_busy = 1'b0;

  always @(posedge iClkIN) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] r, input logic par,
                      input int p, output bit dn);
    int n;
    bit ok;
    @(negedge iClkIN);
    iData = d; iRateSel = r; iValid = 1'b1;
    ok = 1'b0; n = 0; dn = 1'b0;
    while (!ok && n < 4000) begin
      if (oReady) begin
        dn = oFrameDone;
        sb.push_back('{d, par, p, cyc});
        ok = 1'b1;
        @(posedge iClkIN);
        #1 iValid = 1'b0;
      end else begin
        @(negedge iClkIN);
        n++;
      end
    end
    if (!ok) begin
      chk("accept timeout", 0, 1);
      iValid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_busy) && n < 6000) begin
      @(negedge iClkIN);
      n++;
    end
    chk("frames drained", (sb.size() != 0 || mon_busy) ? 0 : 1, 1);
  endtask

  // Frame monitor: pops the expected word on each start bit and checks every cycle.
  initial begin : mon
    exp_t       e;
    logic [10:0] fb;
    int         bad[11];
    bit         ab;
    int         fr;
    fr = 0;
    forever begin
      @(negedge iClkIN);
      if (reset && oBusy && !oSer) begin
        mon_busy = 1'b1;
        if (sb.size() == 0) begin
          chk("unexpected frame start", 1, 0);
        end else begin
          e = sb.pop_front();
          chk_rng($sformatf("frame%0d start latency", fr), cyc - e.acc, 2, e.p + 2);
          fb = {1'b1, e.par, e.data, 1'b0};
          for (int k = 0; k < 11; k++) bad[k] = 0;
          ab = 1'b0;
          for (int c = 0; c < 11 * e.p; c++) begin
            if (c != 0) @(negedge iClkIN);
            if (!reset) begin ab = 1'b1; break; end
            if (oSer !== fb[c / e.p] || oFrameDone !== 1'b0) bad[c / e.p]++;
          end
          if (!ab) begin
            for (int k = 0; k < 11; k++)
              chk($sformatf("frame%0d bit%0d wrong cycles (want level %0b)", fr, k, fb[k]),
                  bad[k], 0);
            @(negedge iClkIN);
            chk($sformatf("frame%0d oFrameDone at end", fr), oFrameDone, 1);
            chk($sformatf("frame%0d oReady at end", fr), oReady, 1);
          end
          fr++;
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : wdog
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit dn;
    int n0, nb, nr;
    vt[0] = '{8'hA5, 2'd0, 1'b0, 2};
    vt[1] = '{8'h01, 2'd3, 1'b1, 16};
    vt[2] = '{8'hFF, 2'd1, 1'b0, 4};
    vt[3] = '{8'h00, 2'd2, 1'b0, 8};
    vt[4] = '{8'h80, 2'd0, 1'b1, 2};
    vt[5] = '{8'h3C, 2'd1, 1'b0, 4};
    vt[6] = '{8'h7E, 2'd0, 1'b0, 2};
    vt[7] = '{8'h5B, 2'd2, 1'b1, 8};
    iData = '0; iRateSel = 2'd0; iValid = 1'b0; div_hold = 1'b0;

    repeat (3) @(negedge iClkIN);
    chk("reset oSer", oSer, 1);
    chk("reset oReady", oReady, 1);
    chk("reset oBusy", oBusy, 0);
    chk("reset oFrameDone", oFrameDone, 0);
    reset = 1'b1;

    // Table vectors sent back to back; later words land in the oFrameDone cycle.
    for (int i = 0; i < 8; i++) begin
      send(vt[i].data, vt[i].rate, vt[i].par, vt[i].p, dn);
      if (i > 0) chk($sformatf("vec%0d accepted in oFrameDone cycle", i), dn, 1);
    end
    drain();

    // Rate select moved mid-frame: this frame stays at /16, the next runs at /2.
    send(8'hC3, 2'd3, 1'b0, 16, dn);
    repeat (64) @(negedge iClkIN);
    iRateSel = 2'd0;
    drain();
    send(8'h96, 2'd0, 1'b0, 2, dn);
    drain();

    // Asynchronous reset mid-frame.
    send(8'h5A, 2'd1, 1'b0, 4, dn);
    repeat (15) @(negedge iClkIN);
    #2 reset = 1'b0;
    #1;
    chk("async reset oSer", oSer, 1);
    chk("async reset oReady", oReady, 1);
    chk("async reset oBusy", oBusy, 0);
    repeat (3) @(posedge iClkIN);
    #1 chk("held reset oFrameDone", oFrameDone, 0);
    @(negedge iClkIN);
    reset = 1'b1;
    sb.delete();
    n0 = 0; nb = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge iClkIN);
      if (!oSer) n0++;
      if (oBusy) nb++;
    end
    chk("line low cycles after abort", n0, 0);
    chk("busy cycles after abort", nb, 0);

    // Stalled divider: FSM parks in ARM with the line idle until reset.
    div_hold = 1'b1;
    repeat (2) @(negedge iClkIN);
    send(8'h3C, 2'd0, 1'b0, 2, dn);
    n0 = 0; nb = 0; nr = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge iClkIN);
      if (!oSer) n0++;
      if (!oBusy) nb++;
      if (oReady) nr++;
    end
    chk("stalled line low cycles", n0, 0);
    chk("stalled not-busy cycles", nb, 0);
    chk("stalled ready cycles", nr, 0);
    reset = 1'b0;
    #1 chk("stall reset oBusy", oBusy, 0);
    sb.delete();
    div_hold = 1'b0;
    repeat (2) @(negedge iClkIN);
    reset = 1'b1;
    send(8'h81, 2'd1, 1'b0, 4, dn);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
